// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - round-robin packet arbiter sharing one stream port
//
// mux: parametric beat selector. Picks DATA_SIZE-bit beat number `sel`
// out of DATA_COUNT packed beats (beat i at [(i+1)*DATA_SIZE-1 : i*DATA_SIZE]).
//   in_data   packed upstream beats
//   sel       beat index
//   out_data  selected beat
//
// rr_stream_arbiter: shares one downstream stream among DATA_COUNT requesters.
// A winner is chosen in ARB with rotating priority starting at ptr; the grant
// is then held in LOCK until the beat flagged last is transferred, so packets
// never interleave. The LOCK data path is purely combinational.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     per-requester beat valid
//   in_data      packed per-requester beats
//   in_last      per-requester end-of-packet flag
//   in_ready     per-requester beat accepted
//   out_valid    downstream beat valid
//   out_data     downstream beat
//   out_last     downstream end-of-packet flag
//   out_ready    downstream accepts beat
//   grant_addr   current / most recent granted requester
//   busy         a packet is locked

module mux #(
  parameter int DATA_SIZE  = 32,
  parameter int DATA_COUNT = 4,
  parameter int ADDR_SIZE  = 2
) (
  input  logic [DATA_SIZE*DATA_COUNT-1:0] in_data,
  input  logic [ADDR_SIZE-1:0]            sel,
  output logic [DATA_SIZE-1:0]            out_data
);

  // Indices >= DATA_COUNT fall back to beat 0.
  always_comb begin
    out_data = in_data[DATA_SIZE-1:0];
    for (int i = 1; i < DATA_COUNT; i++) begin
      if (sel == ADDR_SIZE'(i)) begin
        out_data = in_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

module rr_stream_arbiter #(
  parameter int DATA_SIZE  = 32,
  parameter int DATA_COUNT = 4,
  parameter int ADDR_SIZE  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_COUNT-1:0]           in_valid,
  input  logic [DATA_SIZE*DATA_COUNT-1:0] in_data,
  input  logic [DATA_COUNT-1:0]           in_last,
  output logic [DATA_COUNT-1:0]           in_ready,
  output logic                            out_valid,
  output logic [DATA_SIZE-1:0]            out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [ADDR_SIZE-1:0]            grant_addr,
  output logic                            busy
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_SIZE-1:0] ptr;
  logic [ADDR_SIZE-1:0] ptr_nxt;
  logic [ADDR_SIZE-1:0] grant_nxt;
  logic [ADDR_SIZE-1:0] winner;
  logic                 found;
  logic                 sel_valid;
  logic                 sel_last;

  // base + off modulo DATA_COUNT; base is always < DATA_COUNT.
  function automatic logic [ADDR_SIZE-1:0] wrap_add(input logic [ADDR_SIZE-1:0] base,
                                                    input int                   off);
    int s;
    s = int'(base) + off;
    if (s >= DATA_COUNT) s = s - DATA_COUNT;
    return ADDR_SIZE'(s);
  endfunction

  mux #(
    .DATA_SIZE  (DATA_SIZE),
    .DATA_COUNT (DATA_COUNT),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_mux (
    .in_data  (in_data),
    .sel      (grant_addr),
    .out_data (out_data)
  );

  // Control bits of the granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < DATA_COUNT; i++) begin
      if (grant_addr == ADDR_SIZE'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  // Rotating-priority search. Offsets are scanned from farthest to nearest so
  // the requester closest to ptr is the last assignment and therefore wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = DATA_COUNT - 1; k >= 0; k--) begin
      for (int i = 0; i < DATA_COUNT; i++) begin
        if (wrap_add(ptr, k) == ADDR_SIZE'(i) && in_valid[i]) begin
          found  = 1'b1;
          winner = ADDR_SIZE'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      ptr        <= '0;
      grant_addr <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      grant_addr <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_addr;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    case (state)
      ARB: begin
        if (found) begin
          grant_nxt = winner;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        out_valid = sel_valid;
        out_last  = sel_last;
        for (int i = 0; i < DATA_COUNT; i++) begin
          in_ready[i] = (grant_addr == ADDR_SIZE'(i)) & out_ready;
        end
        if (sel_valid && out_ready && sel_last) begin
          state_nxt = ARB;
          // Skip unused indices so ptr never points past the last requester.
          ptr_nxt   = (grant_addr == ADDR_SIZE'(DATA_COUNT - 1)) ? '0 : grant_addr + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  assign busy = (state == LOCK);

endmodule
